// File: rtl/memaccess_pkg.sv
// Shared types and defaults for the LC3 MemAccess stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package memaccess_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    // Access kind requested by the Controller each cycle.
    typedef enum logic [1:0] {
        MEM_IND  = 2'b00,   // indirect pointer fetch
        MEM_RD   = 2'b01,   // data read
        MEM_WR   = 2'b10,   // data write
        MEM_IDLE = 2'b11    // no access
    } mem_state_e;

    // Stage FSM; WAIT is only reachable in the wait-state build.
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PTR_VALID = 2'b01,
        WAIT      = 2'b10
    } fsm_state_e;

endpackage

// File: rtl/lc3_memaccess_ptr_reg.sv
// Holds the indirect pointer fetched by an LDI/STI pointer-fetch cycle.
// Latency: 1 cycle from load to ptr_q.
// Backpressure: none; the owning FSM decides when to load and when the pointer counts as valid.
module lc3_memaccess_ptr_reg
    import memaccess_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [AW-1:0] ptr_d,
    output logic [AW-1:0] ptr_q
);

    // Capture a new pointer on every fetch; a reset discards it.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (load) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/lc3_memaccess_stage.sv
// LC3 MemAccess stage: sequences direct and indirect loads/stores onto the data memory port.
// Latency: memory port combinational (0 cycles); memout registered (1 cycle).
// Backpressure: none by default; with LC3_MEMACC_WAIT_EN defined, DMem_ready=0 parks the access in WAIT and raises mem_stall.
module lc3_memaccess_stage
    import memaccess_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] M_Addr,
    input  logic [DW-1:0] M_Data,
    input  logic          M_Control,
    input  logic [1:0]    mem_state,
    input  logic [DW-1:0] DMem_dout,
`ifdef LC3_MEMACC_WAIT_EN
    input  logic          DMem_ready,
`endif
    output logic [AW-1:0] DMem_addr,
    output logic [DW-1:0] DMem_din,
    output logic          DMem_rd,
    output logic [DW-1:0] memout,
    output logic          ind_err,
    output logic          mem_stall
);

    mem_state_e    ms;
    fsm_state_e    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          ptr_ld, mem_ld, ind_set, use_ptr;

    assign ms    = mem_state_e'(mem_state);
    assign ptr_d = AW'(DMem_dout);

    lc3_memaccess_ptr_reg #(.AW(AW)) u_ptr_reg (
        .clock (clock),
        .reset (reset),
        .load  (ptr_ld),
        .ptr_d (ptr_d),
        .ptr_q (ptr_q)
    );

`ifdef LC3_MEMACC_WAIT_EN
    // Snapshot of the stalled access so the port stays stable while memory is busy.
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;
    logic          rd_q, ind_q, save;
    mem_state_e    ms_q;
    fsm_state_e    ret_q;

    // Record the access at the cycle it first stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q <= '0;
            din_q  <= '0;
            rd_q   <= 1'b1;
            ind_q  <= 1'b0;
            ms_q   <= MEM_IDLE;
            ret_q  <= IDLE;
        end else if (save) begin
            addr_q <= DMem_addr;
            din_q  <= DMem_din;
            rd_q   <= DMem_rd;
            ind_q  <= M_Control;
            ms_q   <= ms;
            ret_q  <= state_q;
        end
    end
`endif

    // Next-state, port mux and capture enables.
    always_comb begin
        state_d   = state_q;
        ptr_ld    = 1'b0;
        mem_ld    = 1'b0;
        ind_set   = 1'b0;
        mem_stall = 1'b0;
        use_ptr   = ((ms == MEM_RD) || (ms == MEM_WR)) && M_Control && (state_q == PTR_VALID);
        DMem_addr = use_ptr ? ptr_q : M_Addr;
        DMem_din  = M_Data;
        DMem_rd   = (ms != MEM_WR);

        case (ms)
            MEM_IND: begin
                ptr_ld  = 1'b1;
                state_d = PTR_VALID;
            end
            MEM_RD, MEM_WR: begin
                mem_ld = (ms == MEM_RD);
                if (M_Control) begin
                    // An indirect access consumes the pointer whether or not one was there.
                    ind_set = (state_q != PTR_VALID);
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

`ifdef LC3_MEMACC_WAIT_EN
        save = 1'b0;
        if (state_q == WAIT) begin
            // mem_state is ignored here; the stored access drives everything.
            DMem_addr = addr_q;
            DMem_din  = din_q;
            DMem_rd   = rd_q;
            ptr_ld    = 1'b0;
            mem_ld    = 1'b0;
            ind_set   = 1'b0;
            state_d   = WAIT;
            mem_stall = !DMem_ready;
            if (DMem_ready) begin
                case (ms_q)
                    MEM_IND: begin
                        ptr_ld  = 1'b1;
                        state_d = PTR_VALID;
                    end
                    MEM_RD: begin
                        mem_ld  = 1'b1;
                        state_d = ind_q ? IDLE : ret_q;
                    end
                    default: state_d = ind_q ? IDLE : ret_q;
                endcase
            end
        end else if ((ms != MEM_IDLE) && !DMem_ready) begin
            // Error flag is still raised at issue; only the capture is deferred.
            state_d   = WAIT;
            ptr_ld    = 1'b0;
            mem_ld    = 1'b0;
            save      = 1'b1;
            mem_stall = 1'b1;
        end
`endif

        // Never let a write strobe escape while reset is held.
        if (reset) begin
            DMem_addr = M_Addr;
            DMem_rd   = 1'b1;
            mem_stall = 1'b0;
        end
    end

    // FSM state, load result and sticky indirect error.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            memout  <= '0;
            ind_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (mem_ld) begin
                memout <= DMem_dout;
            end
            if (ind_set) begin
                ind_err <= 1'b1;
            end
        end
    end

endmodule
